instruction_fetch: RTL and testbench

Front-end fetch unit for the RV32I core: owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and buffers returned words with their PCs. It is the producer side of the instruction decoder's input, presenting one 32-bit instruction per valid/ready handshake. It also accepts PC redirects from execute (branch/jump) and discards in-flight stale fetches.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instruction_fetch.sv | 175 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I front end: fetch FSM states and fetch-path sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    // RUN issues fetches; FAULT parks the front end after a misaligned redirect
    // until an aligned redirect arrives.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    localparam int INSTR_BYTES  = 4;  // PC increment per fetched word
    localparam int IFETCH_DEPTH = 2;  // in-flight + buffered fetch credits

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO holding WIDTH-bit entries, DEPTH deep, with flush.
// Latency: a push is visible on o_head_dat the cycle after; a pop frees the slot the same edge.
// Backpressure: the caller must not push when full unless it pops in the same cycle; pops on empty are ignored.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_push_dat write side;
//        i_pop read side; i_flush empties the FIFO (wins over push/pop);
//        o_head_dat oldest entry; o_count occupancy; o_full/o_empty status.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_dat,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [WIDTH-1:0]             o_head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so push into a full FIFO is fine then.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch front end: owns the PC, issues word reads to imem, buffers {pc, instr} for the decoder.
// Latency: request valid one cycle after reset release; instruction reaches the decoder the cycle after the memory response.
// Backpressure: at most IFETCH_DEPTH words outstanding+buffered; a decoder stall stops new requests, a held request keeps its address until accepted.
//
// Ports: i_clk/i_rst_n clock and async active-low reset;
//        o_imem_req_valid/i_imem_req_ready/o_imem_req_addr fetch request channel;
//        i_imem_rsp_valid/i_imem_rsp_data in-order read data (no backpressure);
//        i_redirect_valid/i_redirect_pc one-cycle PC redirect from execute;
//        o_instr_valid/i_instr_ready/o_instruction/o_instr_pc decoder channel;
//        o_fetch_fault set while parked after a misaligned redirect target.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [31:0]     i_imem_rsp_data,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [31:0]     o_instruction,
    output logic [XLEN-1:0] o_instr_pc,
    output logic            o_fetch_fault
);

    localparam int CW = $clog2(IFETCH_DEPTH + 1);

    fetch_state_e    r_state;
    fetch_state_e    w_state_n;
    logic            r_req_valid;
    logic            w_req_valid_n;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] w_req_addr_n;
    logic [XLEN-1:0] r_pc;          // address the next new request will use
    logic [XLEN-1:0] w_pc_n;
    logic [XLEN-1:0] w_pc_base;
    logic [1:0]      r_discard;     // responses still owed to the pre-redirect stream
    logic [1:0]      w_discard_n;

    logic            w_req_hs;
    logic            w_req_hold;
    logic            w_push;
    logic            w_pop;
    logic            w_can_issue;
    logic [2:0]      w_out_n;
    logic [2:0]      w_cnt_n;

    logic [XLEN-1:0]    w_rsp_pc;
    logic [CW-1:0]      w_outstanding;
    logic               w_pcq_full;
    logic               w_pcq_empty;
    logic [XLEN+31:0]   w_head;
    logic [CW-1:0]      w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    assign w_req_hs   = r_req_valid && i_imem_req_ready;
    assign w_req_hold = r_req_valid && !i_imem_req_ready;
    assign w_pop      = o_instr_valid && i_instr_ready;
    // Responses arriving during a redirect belong to the old stream and are dropped.
    assign w_push     = i_imem_rsp_valid && (r_discard == 2'd0) && !i_redirect_valid;

    // The PC queue's occupancy is the outstanding-request count.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (IFETCH_DEPTH)
    ) u_pc_q (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_req_hs),
        .i_push_dat (r_req_addr),
        .i_pop      (i_imem_rsp_valid),
        .i_flush    (1'b0),
        .o_head_dat (w_rsp_pc),
        .o_count    (w_outstanding),
        .o_full     (w_pcq_full),
        .o_empty    (w_pcq_empty)
    );

    fetch_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (IFETCH_DEPTH)
    ) u_instr_q (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_push),
        .i_push_dat ({w_rsp_pc, i_imem_rsp_data}),
        .i_pop      (w_pop),
        .i_flush    (i_redirect_valid),
        .o_head_dat (w_head),
        .o_count    (w_fifo_count),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign o_instr_valid    = !w_fifo_empty;
    assign o_instruction    = w_head[31:0];
    assign o_instr_pc       = w_head[XLEN+31:32];
    assign o_imem_req_valid = r_req_valid;
    assign o_imem_req_addr  = r_req_addr;
    assign o_fetch_fault    = (r_state == FAULT);

    // Credit check on the post-edge counts: the new request appears next cycle,
    // when these become the registered outstanding and FIFO counts.
    always_comb begin
        w_out_n     = 3'(w_outstanding) + 3'(w_req_hs) - 3'(i_imem_rsp_valid);
        w_cnt_n     = i_redirect_valid ? 3'd0
                                       : 3'(w_fifo_count) + 3'(w_push) - 3'(w_pop);
        w_can_issue = (w_out_n + w_cnt_n) < 3'(IFETCH_DEPTH);
    end

    always_comb begin
        w_state_n     = r_state;
        w_pc_base     = r_pc;
        w_req_valid_n = 1'b0;
        w_req_addr_n  = r_pc;
        w_pc_n        = r_pc;
        w_discard_n   = r_discard;

        if (i_redirect_valid) begin
            w_state_n = (i_redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
            w_pc_base = i_redirect_pc;
        end
        w_req_addr_n = w_pc_base;
        w_pc_n       = w_pc_base;

        if (w_req_hold) begin
            // An offered request is never withdrawn, even across a redirect.
            w_req_valid_n = 1'b1;
            w_req_addr_n  = r_req_addr;
        end else if ((w_state_n == RUN) && w_can_issue) begin
            w_req_valid_n = 1'b1;
            w_pc_n        = w_pc_base + XLEN'(INSTR_BYTES);
        end

        // Everything already requested (accepted or still offered) and not yet
        // answered belongs to the old stream once a redirect lands.
        if (i_redirect_valid) begin
            w_discard_n = 2'(3'(w_outstanding) + 3'(r_req_valid) - 3'(i_imem_rsp_valid));
        end else if (i_imem_rsp_valid && (r_discard != 2'd0)) begin
            w_discard_n = r_discard - 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= RUN;
            r_req_valid <= 1'b0;
            r_req_addr  <= RESET_PC;
            r_pc        <= RESET_PC;
            r_discard   <= 2'd0;
        end else begin
            r_state     <= w_state_n;
            r_req_valid <= w_req_valid_n;
            r_req_addr  <= w_req_addr_n;
            r_pc        <= w_pc_n;
            r_discard   <= w_discard_n;
        end
    end

    a_instr_q_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_push && w_fifo_full && !w_pop));
    a_pc_q_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_req_hs && w_pcq_full && !i_imem_rsp_valid));
    a_rsp_has_request: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_imem_rsp_valid && w_pcq_empty));

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instruction;
    logic [31:0] o_instr_pc;
    logic        o_fetch_fault;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc;
    int          lat;
    int          pop_cnt;
    int          hs_cnt;
    int          first_vld_cyc;
    int          snap;
    logic [31:0] exp_pc;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] hs_log[$];

    instruction_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_instr_valid    (o_instr_valid),
        .i_instr_ready    (i_instr_ready),
        .o_instruction    (o_instruction),
        .o_instr_pc       (o_instr_pc),
        .o_fetch_fault    (o_fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe handshakes at the negedge, then drive the next cycle's
    // memory response just after the rising edge.
    task automatic step();
        @(negedge clk);
        if (o_instr_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (o_instr_valid && i_instr_ready) begin
            chk("pop_pc", o_instr_pc, exp_pc);
            chk("pop_instr", o_instruction, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pop_cnt++;
        end
        if (i_redirect_valid) exp_pc = i_redirect_pc;
        if (o_imem_req_valid && i_imem_req_ready) begin
            hs_cnt++;
            hs_log.push_back(o_imem_req_addr);
            mq_addr.push_back(o_imem_req_addr);
            mq_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
        i_redirect_valid = 1'b0;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_data  = 32'd0;
        end
    endtask

    task automatic apply_reset();
        rst_n            = 1'b0;
        i_imem_req_ready = 1'b1;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'd0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 32'd0;
        i_instr_ready    = 1'b1;
        mq_addr.delete();
        mq_due.delete();
        hs_log.delete();
        pop_cnt       = 0;
        hs_cnt        = 0;
        first_vld_cyc = -1;
        exp_pc        = 32'd0;
        cyc           = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = pc;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_imem_req_valid && n < 50) begin
            step();
            n++;
        end
        chk(tag, 32'(o_imem_req_valid), 32'd0);
    endtask

    initial begin
        int n;
        lat              = 1;
        cyc              = 0;
        i_imem_req_ready = 1'b1;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'd0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 32'd0;
        i_instr_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        chk("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
        chk("rst_req_addr", o_imem_req_addr, 32'h0000_0000);
        chk("rst_instr_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_instruction", o_instruction, 32'd0);
        chk("rst_instr_pc", o_instr_pc, 32'd0);
        chk("rst_fault", 32'(o_fetch_fault), 32'd0);

        // straight-line fetch, latency 1
        lat = 1;
        apply_reset();
        step();
        chk("t1_req_valid_c1", 32'(o_imem_req_valid), 32'd1);
        chk("t1_req_addr_c1", o_imem_req_addr, 32'h0);
        step();
        step();
        chk("t1_instr_valid_c3", 32'(o_instr_valid), 32'd1);
        chk("t1_instr_pc_c3", o_instr_pc, 32'h0);
        step();
        chk("t1_first_valid_cycle", 32'(first_vld_cyc), 32'd3);
        chk("t1_instr_pc_c4", o_instr_pc, 32'h4);
        repeat (20) step();
        chk("t1_progress", 32'(pop_cnt >= 10), 32'd1);
        // asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_arst_req_valid", 32'(o_imem_req_valid), 32'd0);
        chk("t1_arst_instr_valid", 32'(o_instr_valid), 32'd0);

        // decoder stalled for 10 cycles
        apply_reset();
        i_instr_ready = 1'b0;
        repeat (10) step();
        chk("t2_req_count", 32'(hs_cnt), 32'd2);
        chk("t2_instr_valid", 32'(o_instr_valid), 32'd1);
        chk("t2_head_pc", o_instr_pc, 32'h0);
        chk("t2_head_instr", o_instruction, mem_word(32'h0));
        chk("t2_req_valid", 32'(o_imem_req_valid), 32'd0);
        i_instr_ready = 1'b1;
        repeat (12) step();
        chk("t2_resume", 32'(pop_cnt >= 4), 32'd1);

        // redirect with two requests in flight, latency 3
        lat = 3;
        apply_reset();
        repeat (3) step();
        chk("t3_req_valid_c3", 32'(o_imem_req_valid), 32'd0);
        redirect(32'h0000_0100);
        step();
        chk("t3_req_addr", o_imem_req_addr, 32'h0000_0100);
        repeat (15) step();
        chk("t3_progress", 32'(pop_cnt >= 2), 32'd1);

        // redirect while request to 0x8 is held off by the memory
        lat = 1;
        apply_reset();
        n = 0;
        while (!(o_imem_req_valid && o_imem_req_addr == 32'h8) && n < 50) begin
            step();
            n++;
        end
        chk("t4_req8_seen", 32'(o_imem_req_valid && o_imem_req_addr == 32'h8), 32'd1);
        i_imem_req_ready = 1'b0;
        redirect(32'h0000_0100);
        hs_log.delete();
        repeat (3) step();
        chk("t4_hold_valid", 32'(o_imem_req_valid), 32'd1);
        chk("t4_hold_addr", o_imem_req_addr, 32'h8);
        i_imem_req_ready = 1'b1;
        step();
        chk("t4_new_valid", 32'(o_imem_req_valid), 32'd1);
        chk("t4_new_addr", o_imem_req_addr, 32'h0000_0100);
        repeat (10) step();
        chk("t4_hs0", hs_log[0], 32'h8);
        chk("t4_hs1", hs_log[1], 32'h0000_0100);
        chk("t4_progress", 32'(exp_pc >= 32'h104), 32'd1);

        // misaligned redirect parks fetch; aligned redirect resumes it
        wait_idle("t5_idle");
        redirect(32'h0000_0102);
        step();
        chk("t5_fault_set", 32'(o_fetch_fault), 32'd1);
        snap = hs_cnt;
        repeat (8) step();
        chk("t5_no_requests", 32'(hs_cnt - snap), 32'd0);
        chk("t5_no_instr", 32'(o_instr_valid), 32'd0);
        chk("t5_fault_held", 32'(o_fetch_fault), 32'd1);
        redirect(32'h0000_0200);
        step();
        chk("t5_fault_clear", 32'(o_fetch_fault), 32'd0);
        chk("t5_req_valid", 32'(o_imem_req_valid), 32'd1);
        chk("t5_req_addr", o_imem_req_addr, 32'h0000_0200);
        repeat (10) step();
        chk("t5_progress", 32'(exp_pc >= 32'h208), 32'd1);

        // PC wraps past the top of the address space
        wait_idle("t6_idle");
        hs_log.delete();
        redirect(32'hFFFF_FFF8);
        repeat (12) step();
        chk("t6_hs0", hs_log[0], 32'hFFFF_FFF8);
        chk("t6_hs1", hs_log[1], 32'hFFFF_FFFC);
        chk("t6_hs2_wrap", hs_log[2], 32'h0000_0000);
        chk("t6_progress", 32'(exp_pc >= 32'h4 && exp_pc < 32'h100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
